// File: rtl/mov_word_emitter_pkg.sv
// mov_word_emitter_pkg: shared state enum, default opcode and opcode-word field positions
package mov_word_emitter_pkg;
  typedef enum logic [1:0] {IDLE, OPW, IMMW} state_e;
  localparam logic [7:0] MOV_OPCODE = 8'h01;
  localparam int DST_LSB = 12;
  localparam int IMM_BIT = 11;
  localparam int SRC_LSB = 8;
endpackage

// File: rtl/mov_word_emitter_pack.sv
// mov_word_pack: builds a MOV opcode word from its destination, source and immediate flag
module mov_word_pack
  import mov_word_emitter_pkg::*;
#(
  parameter logic [7:0] OPCODE = MOV_OPCODE
) (
  input  logic [3:0]  dst,
  input  logic [2:0]  src,
  input  logic        imm_en,
  output logic [15:0] word
);
  always_comb begin
    word = '0;
    word[7:0] = OPCODE;
    word[SRC_LSB +: 3] = imm_en ? 3'd0 : src;
    word[IMM_BIT] = imm_en;
    word[DST_LSB +: 4] = dst;
  end
endmodule

// File: rtl/mov_word_emitter.sv
// mov_word_emitter: turns MOV requests into opcode/immediate words on a valid/ready stream
module mov_word_emitter
  import mov_word_emitter_pkg::*;
#(
  parameter logic [7:0] OPCODE = MOV_OPCODE,
  parameter int         CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [3:0]       REQ_DST,
  input  logic [2:0]       REQ_SRC,
  input  logic             REQ_IMM_EN,
  input  logic [15:0]      REQ_IMM,
  output logic [15:0]      O,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             BUSY,
  output logic [CNT_W-1:0] WORD_CNT
);
  state_e             state_q, state_d;
  logic [15:0]        o_q, o_d, imm_q, imm_d, op_word;
  logic               imm_en_q, imm_en_d, xfer, accept, to_imm;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  mov_word_pack #(.OPCODE(OPCODE)) u_pack (
    .dst    (REQ_DST),
    .src    (REQ_SRC),
    .imm_en (REQ_IMM_EN),
    .word   (op_word)
  );

  // A new request may only be taken when the slot empties this cycle, so accept
  // never collides with a pending immediate.
  always_comb begin
    O_VALID = state_q != IDLE;
    BUSY = O_VALID;
    xfer = O_VALID & O_READY;
    to_imm = (state_q == OPW) & imm_en_q;
    REQ_READY = !RST & ((state_q == IDLE) | ((state_q == OPW) & !imm_en_q & O_READY)
                        | ((state_q == IMMW) & O_READY));
    accept = REQ_VALID & REQ_READY;
    state_d = accept ? OPW : xfer ? (to_imm ? IMMW : IDLE) : state_q;
    o_d = accept ? op_word : (xfer & to_imm) ? imm_q : o_q;
    imm_d = accept ? REQ_IMM : imm_q;
    imm_en_d = accept ? REQ_IMM_EN : imm_en_q;
    cnt_d = cnt_q + CNT_W'(xfer);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      o_q <= '0;
      imm_q <= '0;
      imm_en_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      o_q <= o_d;
      imm_q <= imm_d;
      imm_en_q <= imm_en_d;
      cnt_q <= cnt_d;
    end
  end

  assign O = o_q;
  assign WORD_CNT = cnt_q;
endmodule

// File: tb/tb_mov_word_emitter.sv
// tb_mov_word_emitter: queue-based reference model with per-cycle compare plus directed literal checks
module tb_mov_word_emitter;
  localparam int CNT_W = 4;
  logic             CLK = 1'b0, RST = 1'b1;
  logic             REQ_VALID = 1'b0, REQ_READY, REQ_IMM_EN = 1'b0, O_VALID, O_READY = 1'b1, BUSY;
  logic [3:0]       REQ_DST = '0;
  logic [2:0]       REQ_SRC = '0;
  logic [15:0]      REQ_IMM = '0, O;
  logic [CNT_W-1:0] WORD_CNT;
  int               n_cmp = 0, n_bad = 0;

  mov_word_emitter #(.OPCODE(8'h01), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_DST(REQ_DST), .REQ_SRC(REQ_SRC), .REQ_IMM_EN(REQ_IMM_EN), .REQ_IMM(REQ_IMM),
    .O(O), .O_VALID(O_VALID), .O_READY(O_READY), .BUSY(BUSY), .WORD_CNT(WORD_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: words still owed downstream, in order; the block can take a new
  // request only if that backlog is gone by the end of this cycle.
  logic [15:0] q[$];
  int          mcnt = 0;
  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      begin
        logic ev, er, xf, ac;
        ev = q.size() != 0;
        er = !RST && (q.size() == 0 || (q.size() == 1 && O_READY));
        chk("o_valid", 32'(O_VALID), 32'(ev));
        chk("busy", 32'(BUSY), 32'(ev));
        chk("req_ready", 32'(REQ_READY), 32'(er));
        chk("word_cnt", 32'(WORD_CNT), 32'(mcnt));
        if (ev) chk("o_word", 32'(O), 32'(q[0]));
        if (RST) begin
          q.delete();
          mcnt = 0;
        end else begin
          xf = ev && O_READY;
          ac = REQ_VALID && er;
          if (xf) begin
            void'(q.pop_front());
            mcnt = (mcnt + 1) % (1 << CNT_W);
          end
          if (ac) begin
            q.push_back({REQ_DST, REQ_IMM_EN, REQ_IMM_EN ? 3'd0 : REQ_SRC, 8'h01});
            if (REQ_IMM_EN) q.push_back(REQ_IMM);
          end
        end
      end
    end
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic [3:0] d, input logic [2:0] s, input logic ie, input logic [15:0] im);
    REQ_VALID = 1'b1; REQ_DST = d; REQ_SRC = s; REQ_IMM_EN = ie; REQ_IMM = im;
  endtask

  initial begin
    step; step;
    chk("rst_ready", 32'(REQ_READY), 0);
    chk("rst_o", 32'(O), 0);
    chk("rst_valid", 32'(O_VALID), 0);
    chk("rst_cnt", 32'(WORD_CNT), 0);
    chk("rst_busy", 32'(BUSY), 0);
    RST = 1'b0;
    #1 chk("ready_after_rst", 32'(REQ_READY), 1);
    req(4'h3, 3'h5, 1'b0, 16'h0);
    step; REQ_VALID = 1'b0;
    chk("single_word", 32'(O), 32'h3501);
    chk("single_valid", 32'(O_VALID), 1);
    step;
    chk("single_idle", 32'(O_VALID), 0);
    chk("single_cnt", 32'(WORD_CNT), 1);
    req(4'hA, 3'h7, 1'b1, 16'hBEEF);
    step; REQ_VALID = 1'b0;
    chk("imm_op", 32'(O), 32'hA801);
    #1 chk("imm_opw_ready", 32'(REQ_READY), 0);
    step;
    chk("imm_word", 32'(O), 32'hBEEF);
    step;
    chk("imm_cnt", 32'(WORD_CNT), 3);
    req(4'hA, 3'h7, 1'b1, 16'hBEEF);
    step; REQ_VALID = 1'b0; O_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("bp_word", 32'(O), 32'hA801);
      chk("bp_ready", 32'(REQ_READY), 0);
    end
    O_READY = 1'b1;
    step;
    chk("bp_imm", 32'(O), 32'hBEEF);
    step;
    chk("bp_cnt", 32'(WORD_CNT), 5);
    for (int i = 0; i < 4; i++) begin
      req(4'(i + 1), 3'(i), 1'b0, 16'h0);
      step;
      chk("b2b_word", 32'(O), 32'({4'(i + 1), 1'b0, 3'(i), 8'h01}));
    end
    REQ_VALID = 1'b0;
    step;
    chk("b2b_cnt", 32'(WORD_CNT), 9);
    req(4'hC, 3'h1, 1'b1, 16'h1234);
    step; REQ_VALID = 1'b0; RST = 1'b1;
    step; RST = 1'b0;
    chk("midrst_valid", 32'(O_VALID), 0);
    chk("midrst_cnt", 32'(WORD_CNT), 0);
    step; step;
    chk("no_orphan", 32'(O_VALID), 0);
    for (int i = 0; i < 17; i++) begin
      req(4'(i), 3'(i), 1'b0, 16'h0);
      step;
    end
    REQ_VALID = 1'b0;
    step;
    chk("wrap_cnt", 32'(WORD_CNT), 1);
    for (int i = 0; i < 3000; i++) begin
      REQ_VALID = ($urandom % 4) != 0;
      O_READY = ($urandom % 4) != 0;
      REQ_DST = 4'($urandom);
      REQ_SRC = 3'($urandom);
      REQ_IMM_EN = 1'($urandom);
      REQ_IMM = 16'($urandom);
      RST = ($urandom % 200) == 0;
      step;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
